regfile_mp: RTL and testbench

//  Parametrised multi-read-port integer register file for the RV32 core; successor to the single-pair RD1/RD2 file.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/regfile_scoreboard.sv | 71 +++++++
 rtl/regfile_mp.sv | 122 ++++++++++++
 tb/tb_regfile_mp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg -- shared RV32 core definitions.
//   XLEN        : integer register width
//   reg_addr_t  : architectural register index (x0..x31)
//   REG_ZERO    : hardwired-zero register index
//   REG_A0      : first argument / return value register (a0 = x10)
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_A0   = 5'd10;

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard -- per-register busy bits for RAW/WAW hazard detection.
// Built into regfile_mp only when REGFILE_SCOREBOARD_EN is defined.
//
// Ports
//   clk         : clock, all updates on posedge
//   rst_n       : asynchronous active-low reset, clears every busy bit
//   rd_addr_i   : read operand addresses, one per read port
//   wr_en_i     : writeback valid, clears busy[wr_addr_i]
//   wr_addr_i   : writeback destination
//   iss_en_i    : instruction issued, sets busy[iss_addr_i]
//   iss_addr_i  : destination of the issued instruction
//   rd_busy_o   : operand p still has an outstanding producer
//   iss_waw_o   : issue destination already has an outstanding producer
//
// Fixed-timing interface: no valid/ready handshake. Enables are qualifiers
// sampled on every posedge; hazard outputs are combinational from the
// current busy state and the same-cycle writeback.
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int AW     = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD-1:0][AW-1:0]  rd_addr_i,
  input  logic                       wr_en_i,
  input  logic [AW-1:0]              wr_addr_i,
  input  logic                       iss_en_i,
  input  logic [AW-1:0]              iss_addr_i,
  output logic [NUM_RD-1:0]          rd_busy_o,
  output logic                       iss_waw_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clear first, then set: an instruction issued on the same edge that
  // an older producer of the same register writes back keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    if (iss_en_i && (iss_addr_i != AW'(REG_ZERO))) begin
      busy_d[iss_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A writeback in this cycle resolves the hazard because the read path
  // bypasses wr_data into the operand.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_busy
    assign rd_busy_o[p] = busy_q[rd_addr_i[p]] &
                          ~(wr_en_i && (wr_addr_i == rd_addr_i[p]));
  end

  assign iss_waw_o = iss_en_i & busy_q[iss_addr_i] &
                     ~(wr_en_i && (wr_addr_i == iss_addr_i));

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-read-port integer register file for the RV32 core.
// Registered reads (1-cycle latency) with write-to-read bypass, hardwired
// x0, asynchronous clear. Optional busy scoreboard enabled by the macro
// REGFILE_SCOREBOARD_EN.
//
// Ports
//   clk       : clock, all state updates on posedge
//   rst_n     : asynchronous active-low reset
//   rd_addr   : NUM_RD read addresses, sampled at posedge
//   rd_data   : NUM_RD registered read results, valid one cycle later
//   wr_en     : write enable
//   wr_addr   : write address (writes to x0 are dropped)
//   wr_data   : write data
//   dbg_data  : committed value of register DBG_IDX, no bypass
//   iss_en    : [REGFILE_SCOREBOARD_EN] instruction issued
//   iss_addr  : [REGFILE_SCOREBOARD_EN] destination of issued instruction
//   rd_busy   : [REGFILE_SCOREBOARD_EN] operand p has an outstanding producer
//   iss_waw   : [REGFILE_SCOREBOARD_EN] iss_addr already busy
//
// Fixed-latency interface: no valid/ready handshake. wr_en / iss_en are
// qualifiers sampled on every posedge; reads are issued every cycle.
// ---------------------------------------------------------------------------
module regfile_mp
  import riscv_pkg::*;
#(
  parameter int XLEN    = riscv_pkg::XLEN,
  parameter int NREGS   = 32,
  parameter int NUM_RD  = 2,
  parameter int DBG_IDX = int'(REG_A0),
  localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_RD-1:0][AW-1:0]   rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0] rd_data,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [XLEN-1:0]             wr_data,
  output logic [XLEN-1:0]             dbg_data
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                        iss_en,
  input  logic [AW-1:0]               iss_addr,
  output logic [NUM_RD-1:0]           rd_busy,
  output logic                        iss_waw
`endif
);

  if ((NREGS < 2) || (NREGS != (1 << AW))) begin : g_bad_nregs
    $error("regfile_mp: NREGS must be a power of two and >= 2");
  end
  if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be in 1..4");
  end
  if ((DBG_IDX < 0) || (DBG_IDX >= NREGS)) begin : g_bad_dbg_idx
    $error("regfile_mp: DBG_IDX out of range");
  end

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_nz;

  // Entry 0 is never written, so it stays at its reset value of zero.
  assign wr_nz = wr_en && (wr_addr != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_nz) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [XLEN-1:0] rd_d;
    logic [XLEN-1:0] rd_q;

    // x0 check comes first so a same-edge write to x0 is never bypassed.
    always_comb begin
      if (rd_addr[p] == AW'(REG_ZERO)) begin
        rd_d = '0;
      end else if (wr_en && (wr_addr == rd_addr[p])) begin
        rd_d = wr_data;
      end else begin
        rd_d = regs_q[rd_addr[p]];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign rd_data[p] = rd_q;
  end

  assign dbg_data = regs_q[DBG_IDX];

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .AW     (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_i  (rd_addr),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .rd_busy_o  (rd_busy),
    .iss_waw_o  (iss_waw)
  );
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp (XLEN=32, NREGS=32,
// NUM_RD=2, DBG_IDX=10). Scoreboard section compiled in when
// REGFILE_SCOREBOARD_EN is defined.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int AW     = 5;
  localparam int NUM_RD = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_RD-1:0][AW-1:0]   rd_addr = '0;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;
  logic                        wr_en   = 1'b0;
  logic [AW-1:0]               wr_addr = '0;
  logic [XLEN-1:0]             wr_data = '0;
  logic [XLEN-1:0]             dbg_data;
`ifdef REGFILE_SCOREBOARD_EN
  logic                        iss_en   = 1'b0;
  logic [AW-1:0]               iss_addr = '0;
  logic [NUM_RD-1:0]           rd_busy;
  logic                        iss_waw;
`endif

  regfile_mp #(
    .XLEN    (XLEN),
    .NREGS   (32),
    .NUM_RD  (NUM_RD),
    .DBG_IDX (10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dbg_data (dbg_data)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_busy  (rd_busy),
    .iss_waw  (iss_waw)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] mdl [32];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] mdl_read(input logic we,
      input logic [AW-1:0] wa, input logic [XLEN-1:0] wd, input logic [AW-1:0] ra);
    if (ra == 0) return '0;
    if (we && (wa == ra)) return wd;
    return mdl[ra];
  endfunction

  // ---------------- driver ----------------
  // One clocked read/write cycle: drive at negedge, expectations go into
  // exp_q, read data is popped and compared 1 ns after the sampling edge.
  task automatic step(input string name, input logic we, input logic [AW-1:0] wa,
                      input logic [XLEN-1:0] wd, input logic [AW-1:0] ra0,
                      input logic [AW-1:0] ra1, input logic [XLEN-1:0] e0,
                      input logic [XLEN-1:0] e1);
    logic [XLEN-1:0] x;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr[0] = ra0; rd_addr[1] = ra1;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    if (we && (wa != 0)) mdl[wa] = wd;
    @(posedge clk);
    #1;
    if (exp_q.size() < 2) begin
      check({name, "_qempty"}, 32'(exp_q.size()), 32'd2);
    end else begin
      x = exp_q.pop_front(); check({name, "_rd0"}, rd_data[0], x);
      x = exp_q.pop_front(); check({name, "_rd1"}, rd_data[1], x);
    end
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    logic [XLEN-1:0] e0;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] edbg;
  } vec_t;

  vec_t vecs[13];

  // Watchdog: the bench only waits on its own clock, this is a backstop.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] e0, e1, wd;
    logic [AW-1:0]   wa, ra0, ra1;
    logic            we;

    for (int i = 0; i < 32; i++) mdl[i] = '0;

    //            we  wa     wd              ra0    ra1    e0             e1             dbg
    vecs[0]  = '{1'b1, 5'd3,  32'h1234_5678, 5'd0,  5'd3,  32'h0,         32'h1234_5678, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         5'd3,  5'd3,  32'h1234_5678, 32'h1234_5678, 32'h0};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0,         32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd3,  32'h0,         32'h1234_5678, 32'h0};
    vecs[4]  = '{1'b1, 5'd7,  32'h0000_0011, 5'd7,  5'd0,  32'h0000_0011, 32'h0,         32'h0};
    vecs[5]  = '{1'b1, 5'd7,  32'hA5A5_0001, 5'd3,  5'd7,  32'h1234_5678, 32'hA5A5_0001, 32'h0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  32'hA5A5_0001, 32'hA5A5_0001, 32'h0};
    vecs[7]  = '{1'b0, 5'd3,  32'hDEAD_DEAD, 5'd3,  5'd1,  32'h1234_5678, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 5'd10, 32'd42,        5'd10, 5'd31, 32'd42,        32'h0,         32'd42};
    vecs[9]  = '{1'b1, 5'd11, 32'd7,         5'd11, 5'd10, 32'd7,         32'd42,        32'd42};
    vecs[10] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd1,  32'hCAFE_F00D, 32'h0,         32'd42};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd10, 32'hCAFE_F00D, 32'd42,        32'd42};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd11, 32'h0,         32'd7,         32'd42};

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd0", rd_data[0], '0);
    check("rst_rd1", rd_data[1], '0);
    check("rst_dbg", dbg_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 13; i++) begin
      step($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd,
           vecs[i].ra0, vecs[i].ra1, vecs[i].e0, vecs[i].e1);
      check($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].edbg);
    end

    // ---- random traffic against the reference model ----
    for (int i = 0; i < 60; i++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = AW'($urandom_range(0, 7));
      wd  = $urandom;
      ra0 = AW'($urandom_range(0, 7));
      ra1 = (i % 4 == 0) ? ra0 : AW'($urandom_range(0, 7));
      e0  = mdl_read(we, wa, wd, ra0);
      e1  = mdl_read(we, wa, wd, ra1);
      step($sformatf("rnd%0d", i), we, wa, wd, ra0, ra1, e0, e1);
    end

    // ---- asynchronous reset mid-run ----
    step("x5_wr", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 32'h0, 32'h0);
    step("x5_rd", 1'b0, 5'd0, 32'h0, 5'd5, 5'd10, 32'hDEAD_BEEF, 32'd42);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h0000_0066;
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd0", rd_data[0], '0);
    check("arst_rd1", rd_data[1], '0);
    check("arst_dbg", dbg_data, '0);
    @(posedge clk);
    #1;
    check("arst_hold_rd0", rd_data[0], '0);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    step("post_rst_x5_x6", 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 32'h0, 32'h0);
    step("post_rst_x10",   1'b0, 5'd0, 32'h0, 5'd10, 5'd5, 32'h0, 32'h0);

`ifdef REGFILE_SCOREBOARD_EN
    // ---- busy scoreboard ----
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 5'd4; rd_addr[0] = 5'd4; wr_en = 1'b0;
    #1;
    check("sb_first_iss_waw", 32'(iss_waw), 32'd0);
    @(posedge clk);
    @(negedge clk);
    iss_en = 1'b0;
    #1;
    check("sb_busy_after_iss", 32'(rd_busy[0]), 32'd1);
    iss_en = 1'b1;
    #1;
    check("sb_waw_while_busy", 32'(iss_waw), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iss_en = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h4;
    #1;
    check("sb_wb_bypass", 32'(rd_busy[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check("sb_cleared", 32'(rd_busy[0]), 32'd0);
    iss_en = 1'b1; iss_addr = 5'd4;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd4; iss_en = 1'b1; iss_addr = 5'd4;
    #1;
    check("sb_same_edge_waw", 32'(iss_waw), 32'd0);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; iss_en = 1'b0;
    #1;
    check("sb_set_wins", 32'(rd_busy[0]), 32'd1);
    iss_en = 1'b1; iss_addr = 5'd0;
    @(posedge clk);
    @(negedge clk);
    iss_en = 1'b0; rd_addr[1] = 5'd0;
    #1;
    check("sb_x0_never_busy", 32'(rd_busy[1]), 32'd0);
    check("sb_x4_still_busy", 32'(rd_busy[0]), 32'd1);
`endif

    if (exp_q.size() != 0) begin
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
